// File: rtl/worley_point_scheduler_if.sv
// Handshake/bus bundle between the sync-side controller and the Worley point scheduler.
interface worley_point_scheduler_if #(
    parameter int unsigned NUM_POINTS = 4,
    parameter int unsigned COORD_W    = 10
);
    logic                             frame_tick;
    logic                             freeze;
    logic [NUM_POINTS*COORD_W-1:0]    point_x;
    logic [NUM_POINTS*COORD_W-1:0]    point_y;
    logic                             busy;
    logic                             done;
    logic                             overrun;
    logic [15:0]                      frame_cnt;

    modport master (
        output frame_tick, freeze,
        input  point_x, point_y, busy, done, overrun, frame_cnt
    );

    modport slave (
        input  frame_tick, freeze,
        output point_x, point_y, busy, done, overrun, frame_cnt
    );
endinterface

// File: rtl/worley_point_scheduler.sv
// Per-frame animator for the Worley feature points: one shared add/reflect unit, atomic publish.
// Optional feature macro: WORLEY_SCHED_LFSR_EN (LFSR-chosen speed magnitude on each bounce).
module worley_point_scheduler #(
    parameter int unsigned NUM_POINTS = 4,
    parameter int unsigned COORD_W    = 10,
    parameter int unsigned H_MAX      = 639,
    parameter int unsigned V_MAX      = 479
) (
    input  logic                     clk,
    input  logic                     reset,
    worley_point_scheduler_if.slave  bus
);
    localparam int unsigned SW    = COORD_W + 2;
    localparam int unsigned IDX_W = (NUM_POINTS > 1) ? $clog2(NUM_POINTS) : 1;
    localparam int unsigned PW    = NUM_POINTS * COORD_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPD_X  = 2'd1,
        UPD_Y  = 2'd2,
        COMMIT = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [COORD_W-1:0]      x_q  [NUM_POINTS];
    logic [COORD_W-1:0]      x_d  [NUM_POINTS];
    logic [COORD_W-1:0]      y_q  [NUM_POINTS];
    logic [COORD_W-1:0]      y_d  [NUM_POINTS];
    logic signed [3:0]       vx_q [NUM_POINTS];
    logic signed [3:0]       vx_d [NUM_POINTS];
    logic signed [3:0]       vy_q [NUM_POINTS];
    logic signed [3:0]       vy_d [NUM_POINTS];
    logic [PW-1:0]           pub_x_q, pub_x_d;
    logic [PW-1:0]           pub_y_q, pub_y_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    overrun_q, overrun_d;
    logic [15:0]             frame_cnt_q, frame_cnt_d;

    logic                    is_y;
    logic [COORD_W-1:0]      sel_pos;
    logic signed [3:0]       sel_v;
    logic signed [3:0]       bounce_v;
    logic signed [SW-1:0]    sum;
    logic signed [SW-1:0]    max_s;
    logic [COORD_W-1:0]      upd_pos;
    logic signed [3:0]       upd_v;

    function automatic logic [COORD_W-1:0] rst_x(input int i);
        case (i)
            0:       rst_x = COORD_W'(100);
            1:       rst_x = COORD_W'(300);
            2:       rst_x = COORD_W'(500);
            default: rst_x = COORD_W'(100);
        endcase
    endfunction

    function automatic logic [COORD_W-1:0] rst_y(input int i);
        case (i)
            0:       rst_y = COORD_W'(100);
            1:       rst_y = COORD_W'(200);
            2:       rst_y = COORD_W'(400);
            default: rst_y = COORD_W'(400);
        endcase
    endfunction

    function automatic logic signed [3:0] rst_vx(input int i);
        case (i)
            0:       rst_vx = 4'sd1;
            1:       rst_vx = -4'sd2;
            2:       rst_vx = 4'sd2;
            default: rst_vx = -4'sd1;
        endcase
    endfunction

    function automatic logic signed [3:0] rst_vy(input int i);
        case (i)
            0:       rst_vy = -4'sd1;
            1:       rst_vy = 4'sd2;
            2:       rst_vy = -4'sd1;
            default: rst_vy = -4'sd3;
        endcase
    endfunction

`ifdef WORLEY_SCHED_LFSR_EN
    logic [15:0] lfsr_q, lfsr_d;
    logic [2:0]  mag;

    // Bounce keeps the reflected sign but takes a pseudo-random nonzero magnitude.
    always_comb begin
        lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        mag      = (lfsr_q[2:0] == 3'd0) ? 3'd1 : lfsr_q[2:0];
        bounce_v = sel_v[3] ? $signed({1'b0, mag}) : -$signed({1'b0, mag});
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) lfsr_q <= 16'hACE1;
        else       lfsr_q <= lfsr_d;
    end
`else
    always_comb bounce_v = -sel_v;
`endif

    // Shared add/reflect unit, steered by the sweep state and index.
    always_comb begin
        is_y    = (state_q == UPD_Y);
        sel_pos = is_y ? y_q[idx_q]  : x_q[idx_q];
        sel_v   = is_y ? vy_q[idx_q] : vx_q[idx_q];
        max_s   = is_y ? SW'(V_MAX) : SW'(H_MAX);
        sum     = $signed({2'b00, sel_pos}) + $signed({{(SW-4){sel_v[3]}}, sel_v});
        upd_pos = sum[COORD_W-1:0];
        upd_v   = sel_v;
        if (sum[SW-1]) begin
            upd_pos = '0;
            upd_v   = bounce_v;
        end else if (sum > max_s) begin
            upd_pos = max_s[COORD_W-1:0];
            upd_v   = bounce_v;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        x_d         = x_q;
        y_d         = y_q;
        vx_d        = vx_q;
        vy_d        = vy_q;
        pub_x_d     = pub_x_q;
        pub_y_d     = pub_y_q;
        frame_cnt_d = frame_cnt_q;
        done_d      = 1'b0;
        overrun_d   = overrun_q;

        case (state_q)
            IDLE: begin
                if (bus.frame_tick && !bus.freeze) begin
                    idx_d   = '0;
                    state_d = UPD_X;
                end
            end
            UPD_X: begin
                x_d[idx_q]  = upd_pos;
                vx_d[idx_q] = upd_v;
                state_d     = UPD_Y;
            end
            UPD_Y: begin
                y_d[idx_q]  = upd_pos;
                vy_d[idx_q] = upd_v;
                if (idx_q == IDX_W'(NUM_POINTS - 1)) begin
                    state_d = COMMIT;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = UPD_X;
                end
            end
            COMMIT: begin
                for (int i = 0; i < int'(NUM_POINTS); i++) begin
                    pub_x_d[i*int'(COORD_W) +: COORD_W] = x_q[i];
                    pub_y_d[i*int'(COORD_W) +: COORD_W] = y_q[i];
                end
                frame_cnt_d = frame_cnt_q + 16'd1;
                done_d      = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Any tick outside IDLE (COMMIT included) is dropped and flagged.
        if (bus.frame_tick && (state_q != IDLE)) overrun_d = 1'b1;
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
            frame_cnt_q <= '0;
            for (int i = 0; i < int'(NUM_POINTS); i++) begin
                x_q[i]  <= rst_x(i);
                y_q[i]  <= rst_y(i);
                vx_q[i] <= rst_vx(i);
                vy_q[i] <= rst_vy(i);
                pub_x_q[i*int'(COORD_W) +: COORD_W] <= rst_x(i);
                pub_y_q[i*int'(COORD_W) +: COORD_W] <= rst_y(i);
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            x_q         <= x_d;
            y_q         <= y_d;
            vx_q        <= vx_d;
            vy_q        <= vy_d;
            pub_x_q     <= pub_x_d;
            pub_y_q     <= pub_y_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            overrun_q   <= overrun_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign bus.point_x   = pub_x_q;
    assign bus.point_y   = pub_y_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.overrun   = overrun_q;
    assign bus.frame_cnt = frame_cnt_q;
endmodule

// File: doc/worley_point_scheduler.md
# worley_point_scheduler

Frame-rate controller that owns and animates the feature-point set consumed by the Worley noise datapath. Once per frame, on a vertical-blank tick from the sync generator, it walks all feature points through one shared add/reflect unit and updates each point's position and velocity. It then publishes the new set atomically, so the per-pixel distance logic never sees a half-updated frame. It sits between `hvsync_generator` (tick source) and the noise generator (point consumer) in `tt_um_mo_module`.

## Interface
- `NUM_POINTS`, 4: number of feature points; legal range 1–4.
- `COORD_W`, 10: coordinate width in bits.
- `H_MAX`, 639: largest legal x coordinate.
- `V_MAX`, 479: largest legal y coordinate.

- `clk` in 1: pixel clock.
- `reset` in 1: asynchronous, active-high reset.
- `frame_tick` in 1: one-cycle pulse at the start of vertical blank.
- `freeze` in 1: level; while high, the point set is held.
- `point_x` out NUM_POINTS*COORD_W: published x coordinates; point i is at bits [i*COORD_W +: COORD_W].
- `point_y` out NUM_POINTS*COORD_W: published y coordinates, same packing.
- `busy` out 1: an update sweep is in progress.
- `done` out 1: one-cycle pulse when a new set is published.
- `overrun` out 1: sticky flag; a tick arrived while busy.
- `frame_cnt` out 16: count of published frames; wraps modulo 2^16.

## Operation
- Per point, the block holds a working x/y (COORD_W bits) and a velocity vx/vy (4-bit signed, range −7..+7; −8 is never produced).
- Reset table (entries 0..NUM_POINTS−1):
  - P0: (100,100), v(+1,−1)
  - P1: (300,200), v(−2,+2)
  - P2: (500,400), v(+2,−1)
  - P3: (100,400), v(−1,−3)
- The published outputs equal the working registers at reset.
- FSM states: IDLE, UPD_X, UPD_Y, COMMIT.
  - IDLE: if `frame_tick` and not `freeze`, set idx=0 and go to UPD_X.
  - UPD_X: update x[idx], then go to UPD_Y.
  - UPD_Y: update y[idx]. If idx==NUM_POINTS−1, go to COMMIT; otherwise increment idx and go to UPD_X.
  - COMMIT: copy working x/y to `point_x`/`point_y`, increment `frame_cnt`, pulse `done`, go to IDLE.
- Axis update (one shared unit, COORD_W+2-bit signed arithmetic):
  - s = pos + v.
  - If s < 0: pos = 0, v = −v.
  - Else if s > MAX: pos = MAX, v = −v. MAX is H_MAX for x, V_MAX for y.
  - Else: pos = s, v unchanged.
- `frame_tick` while busy (any non-IDLE state) is ignored and sets `overrun`. `overrun` is cleared only by reset.
- `freeze` high in IDLE: the tick is ignored and `overrun` is not set. `freeze` has no effect once a sweep has started; the sweep completes.
- `busy` is high exactly in the non-IDLE states.

## Timing
- Let E0 be the edge that samples an accepted tick. `busy` is high from E0.
- Sweep occupies 2·NUM_POINTS cycles, then COMMIT. `point_x`/`point_y`/`frame_cnt` change at edge E(2·NUM_POINTS+1), which is E9 for N=4. `done` is high for the cycle after that edge, and `busy` falls at the same edge.
- Published outputs are stable for the entire sweep; they change only at COMMIT.
- A tick coincident with COMMIT counts as overrun; there is no back-to-back acceptance.
- Reset asserted at any point (including mid-sweep) immediately restores the reset table to both working and published registers. It also clears `busy`, `done`, `overrun` and `frame_cnt`, and returns the FSM to IDLE.

## Configuration
- `WORLEY_SCHED_LFSR_EN`:
  - Defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 0xACE1; advances every cycle) supplies the magnitude on each bounce. The new v takes the reflected sign with magnitude = LFSR[2:0], and a value of 0 maps to 1.
  - Undefined: the LFSR is absent, and a bounce only negates v, as above.

## Test plan
- Reset → `point_x` holds 100,300,500,100 and `point_y` holds 100,200,400,400; `busy`=0, `overrun`=0, `frame_cnt`=0.
- One tick (N=4) → outputs unchanged through E8. At E9, P0=(101,99), P1=(298,202), P2=(502,399), P3=(99,397); `done` pulses once; `frame_cnt`=1.
- 100 ticks → P0.y=0. Tick 101 → P0.y=0 with vy=+1 (clamp). Tick 102 → P0.y=1 (bounce, macro undefined).
- Second tick 3 cycles after an accepted tick → ignored; `overrun`=1 and stays 1 across later frames; results match a single update.
- `freeze`=1 with a tick in IDLE → no `busy`, no `done`, outputs and `frame_cnt` unchanged, `overrun`=0.
- Reset asserted at E4 of a sweep → outputs return to the reset table asynchronously; a subsequent tick yields the same values as the one-tick scenario.
